// File: rtl/xor_update_issuer_if.sv
// Bundles the op request stream, the table-side issue/write signals, the query result stream
// and the status outputs of xor_update_issuer.
interface xor_update_issuer_if #(
  parameter int NUM_MUL     = 4,
  parameter int INDEX_WIDTH = 12,
  parameter int DATA_WIDTH  = 64
);
  logic                          in_valid;
  logic                          in_ready;
  logic                          in_op;
  logic [INDEX_WIDTH-1:0]        in_index;
  logic [NUM_MUL*DATA_WIDTH-1:0] in_data;
  logic [NUM_MUL-1:0]            in_mask;

  logic [INDEX_WIDTH-1:0]        rd_index;
  logic [INDEX_WIDTH-1:0]        write_reg_0_index;
  logic                          write_reg_0_valid;
  logic [NUM_MUL*DATA_WIDTH-1:0] rd_out_update;
  logic [NUM_MUL*DATA_WIDTH-1:0] write_reg_11_xor;
  logic [NUM_MUL-1:0]            arbiter_result;

  logic                          q_valid;
  logic                          q_ready;
  logic [INDEX_WIDTH-1:0]        q_index;
  logic [NUM_MUL*DATA_WIDTH-1:0] q_data;

  logic                          init_done;
  logic [31:0]                   stat_updates;
  logic [31:0]                   stat_queries;

  modport slave (
    input  in_valid, in_op, in_index, in_data, in_mask, rd_out_update, q_ready,
    output in_ready, rd_index, write_reg_0_index, write_reg_0_valid, write_reg_11_xor,
           arbiter_result, q_valid, q_index, q_data, init_done, stat_updates, stat_queries
  );

  modport master (
    output in_valid, in_op, in_index, in_data, in_mask, rd_out_update, q_ready,
    input  in_ready, rd_index, write_reg_0_index, write_reg_0_valid, write_reg_11_xor,
           arbiter_result, q_valid, q_index, q_data, init_done, stat_updates, stat_queries
  );
endinterface

// File: rtl/xor_update_issuer.sv
// Request-side front end of the banked XOR-hash table: zero-fill sweep after reset, fixed
// 2-cycle issue/write pipeline, buffered query results. Define XOR_ISSUER_STATS_EN for op counters.
module xor_update_issuer #(
  parameter int NUM_MUL     = 4,
  parameter int INDEX_WIDTH = 12,
  parameter int DATA_WIDTH  = 64,
  parameter int Q_DEPTH     = 4
) (
  input logic                clk,
  input logic                reset,
  xor_update_issuer_if.slave bus
);
  localparam int LW = NUM_MUL * DATA_WIDTH;
  localparam int PW = $clog2(Q_DEPTH);
  localparam int CW = PW + 2;
  // Last issued index reaches stage 11 while the counter reads depth+1.
  localparam logic [INDEX_WIDTH:0] INIT_END = (INDEX_WIDTH + 1)'((1 << INDEX_WIDTH) + 1);

  typedef enum logic {INIT, RUN} state_t;

  state_t                 state;
  logic [INDEX_WIDTH:0]   init_cnt;
  logic                   init_done_q;
  logic [INDEX_WIDTH-1:0] rd_index_q;

  logic                   run_ok;
  logic                   init_issue;
  logic                   accept;
  logic                   q_full_pred;
  logic [CW-1:0]          q_inflight;
  logic [INDEX_WIDTH-1:0] rd_idx_c;

  logic                   vld_p0, op_p0;
  logic [INDEX_WIDTH-1:0] idx_p0;
  logic [LW-1:0]          data_p0;
  logic [NUM_MUL-1:0]     mask_p0;

  logic                   vld_p1, op_p1;
  logic [INDEX_WIDTH-1:0] idx_p1;
  logic [LW-1:0]          data_p1;
  logic [NUM_MUL-1:0]     mask_p1;

  logic                   vld_p2, op_p2;
  logic [INDEX_WIDTH-1:0] idx_p2;
  logic [LW-1:0]          data_p2;
  logic [NUM_MUL-1:0]     mask_p2;

  logic [CW-1:0]          q_cnt;
  logic [PW-1:0]          wr_ptr, rd_ptr;
  logic [INDEX_WIDTH-1:0] qi_mem [Q_DEPTH];
  logic [LW-1:0]          qd_mem [Q_DEPTH];
  logic                   q_valid_c;
  logic                   push, pop;

  // Stage 0: accept/issue, combinational from the request
  always_comb begin
    run_ok       = (state == RUN) && !reset;
    init_issue   = (state == INIT) && !init_cnt[INDEX_WIDTH] && !reset;
    q_inflight   = CW'(vld_p1 & op_p1) + CW'(vld_p2 & op_p2);
    q_full_pred  = (q_cnt + q_inflight) >= CW'(Q_DEPTH);
    bus.in_ready = run_ok && (!bus.in_op || !q_full_pred);
    accept       = bus.in_valid && bus.in_ready;

    vld_p0  = init_issue || accept;
    op_p0   = run_ok && bus.in_op;
    idx_p0  = run_ok ? bus.in_index : init_cnt[INDEX_WIDTH-1:0];
    data_p0 = run_ok ? bus.in_data : '0;
    mask_p0 = run_ok ? bus.in_mask : '1;

    rd_idx_c              = vld_p0 ? idx_p0 : rd_index_q;
    bus.rd_index          = rd_idx_c;
    bus.write_reg_0_index = rd_idx_c;
    bus.write_reg_0_valid = vld_p0 && !op_p0;
  end

  // Stage 11: write-back and query capture
  always_comb begin
    bus.arbiter_result   = (vld_p2 && !op_p2) ? mask_p2 : '0;
    bus.write_reg_11_xor = (state == RUN) ? (bus.rd_out_update ^ data_p2) : '0;
    push                 = vld_p2 && op_p2;
    q_valid_c            = (q_cnt != '0);
    pop                  = q_valid_c && bus.q_ready;
    bus.q_valid          = q_valid_c;
    bus.q_index          = q_valid_c ? qi_mem[rd_ptr] : '0;
    bus.q_data           = q_valid_c ? qd_mem[rd_ptr] : '0;
  end

  assign bus.init_done = init_done_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= INIT;
      init_cnt    <= '0;
      init_done_q <= 1'b0;
      rd_index_q  <= '0;
      vld_p1      <= 1'b0;
      vld_p2      <= 1'b0;
      q_cnt       <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
    end else begin
      case (state)
        INIT: begin
          if (init_cnt == INIT_END) begin
            state       <= RUN;
            init_done_q <= 1'b1;
          end else begin
            init_cnt <= init_cnt + (INDEX_WIDTH + 1)'(1);
          end
        end
        default: ;
      endcase
      rd_index_q <= rd_idx_c;
      vld_p1     <= vld_p0;
      vld_p2     <= vld_p1;
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      q_cnt <= q_cnt + CW'(push) - CW'(pop);
    end
  end

  // Stage 1 -> stage 11 payload and FIFO storage carry no reset
  always_ff @(posedge clk) begin
    op_p1   <= op_p0;
    idx_p1  <= idx_p0;
    data_p1 <= data_p0;
    mask_p1 <= mask_p0;
    op_p2   <= op_p1;
    idx_p2  <= idx_p1;
    data_p2 <= data_p1;
    mask_p2 <= mask_p1;
    if (push) begin
      qi_mem[wr_ptr] <= idx_p2;
      qd_mem[wr_ptr] <= bus.rd_out_update;
    end
  end

`ifdef XOR_ISSUER_STATS_EN
  logic [31:0] stat_upd_q;
  logic [31:0] stat_qry_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      stat_upd_q <= '0;
      stat_qry_q <= '0;
    end else if (state == RUN) begin
      if (vld_p2 && !op_p2) stat_upd_q <= stat_upd_q + 32'd1;
      if (pop)              stat_qry_q <= stat_qry_q + 32'd1;
    end
  end

  assign bus.stat_updates = stat_upd_q;
  assign bus.stat_queries = stat_qry_q;
`else
  assign bus.stat_updates = '0;
  assign bus.stat_queries = '0;
`endif
endmodule
